uart_rx_packer: RTL and testbench
=================================

# uart_rx_packer

Parametrised UART receive packer. It pops bytes from the UART RX FIFO and assembles `BYTES` consecutive bytes into one `8*BYTES`-bit word, with selectable byte order. It discards incomplete words on an inter-byte timeout or an explicit flush. It sits between the UART RX FIFO and the game-control command decoder, and generalises the fixed 2-byte `{MSB, LSB}` receive controller.

## Interface
Parameters:
- `BYTES`, 2: bytes per output word; legal range 1..8.
- `MSB_FIRST`, 1: 1 = first received byte goes to the top byte `[8*BYTES-1 -: 8]`; 0 = first byte goes to `[7:0]`.
- `TIMEOUT_CYCLES`, 100000: idle cycles allowed between bytes of a partial word before it is discarded; 0 disables the timeout.

Ports:
- `clk`, in, 1: system clock; the block uses one clock.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: synchronous clear of any partial word.
- `rx_empty`, in, 1: RX FIFO empty flag.
- `r_data`, in, 8: byte at the FIFO head.
- `rd_uart`, out, 1: one-cycle FIFO pop strobe.
- `uart_en`, out, 1: one-cycle pulse; `uart_data` carries a new word.
- `uart_data`, out, 8*BYTES: last completed word.
- `timeout_err`, out, 1: one-cycle pulse; a partial word was dropped by timeout.
- `busy`, out, 1: high while a partial word is held (byte index > 0).

## Operation
- Byte index `idx` counts 0..BYTES-1, in `$clog2(BYTES+1)` bits. There are two states: `ST_IDLE` (idx = 0) and `ST_COLLECT` (idx > 0).
- Accept condition: `!rx_empty && !rd_uart && !flush`. On accept, the block captures `r_data` into the shift/assembly register at the slot for `idx` under `MSB_FIRST` ordering, and sets `rd_uart_nxt` to 1.
- On accept with idx < BYTES-1: idx increments, and the state becomes or stays `ST_COLLECT`.
- On accept with idx = BYTES-1: `uart_data_nxt` is the completed word, `uart_en_nxt` is 1, idx returns to 0, and the state returns to `ST_IDLE`. For BYTES = 1, every accepted byte completes a word.
- Bytes of the word other than the last come from the assembly register. `uart_data` holds its value until the next completed word; it is not cleared on timeout or flush.
- Timeout counter: counts cycles in `ST_COLLECT`, clears on each accept, and saturates.
  - When the count reaches TIMEOUT_CYCLES-1 with no accept in that cycle, the block clears idx, returns to `ST_IDLE`, and sets `timeout_err_nxt` to 1.
  - When TIMEOUT_CYCLES = 0, the counter and `timeout_err` are tied off to 0.
- Flush: idx goes to 0 and the state goes to `ST_IDLE`. There is no pop and no `uart_en` that cycle, and `timeout_err` is not asserted.
- Simultaneous events:
  - Flush and a byte available: flush wins and the byte stays in the FIFO.
  - Timeout expiry and accept in the same cycle: accept wins and the timer restarts.
  - Flush during timeout expiry: flush wins and there is no `timeout_err`.
- Assembly-register contents are don't-care between words. Unwritten slots are never exposed, because `uart_data` only updates on word completion.

## Timing
- All outputs are registered. Reset values: `rd_uart`=0, `uart_en`=0, `uart_data`=0, `timeout_err`=0, `busy`=0. Also reset: idx=0, state=`ST_IDLE`, timeout counter=0.
- Reset mid-word drops the partial word silently. The first byte after reset goes to slot 0.
- Byte accepted at edge t → `rd_uart` is high during cycle t+1 → the FIFO pops at edge t+1.
- `rd_uart` gates accept, so throughput is at most 1 byte per 2 cycles. The next byte can be accepted at edge t+2.
- For the last byte, `uart_en` and the new `uart_data` are valid in the same cycle as its `rd_uart` (t+1).
- Word latency with the FIFO never empty is 2*BYTES-1 cycles from the first accept edge to `uart_en`.
- `busy` is registered and reflects idx after each edge.
- `timeout_err` asserts in the cycle after the expiry edge, for exactly one cycle.

## Test plan
- BYTES=2, MSB_FIRST=1; FIFO preloaded with 0xA5, 0x3C → exactly two `rd_uart` pulses, then `uart_en` for one cycle with `uart_data`=0xA53C; `uart_data` holds afterwards.
- BYTES=4, MSB_FIRST=0; bytes 0x11, 0x22, 0x33, 0x44 back to back → `uart_data`=0x44332211; `uart_en` 7 cycles after the first accept edge; `rd_uart` never high on two consecutive cycles.
- TIMEOUT_CYCLES=16, BYTES=2; send 0x55 then starve the FIFO → `timeout_err` pulses once, `busy` falls, no `uart_en`. Then 0xDE, 0xAD → `uart_data`=0xDEAD.
- BYTES=3; two bytes sent, then `flush` asserted while a third byte is already in the FIFO → no pop in the flush cycle, idx=0. The next three bytes 0x01, 0x02, 0x03 → 0x010203.
- `rst` asserted after the first byte of a 2-byte word → all outputs return to 0. A subsequent 0xBE, 0xEF → 0xBEEF.
- BYTES=1; stream 0x00..0x0F → 16 `uart_en` pulses, each carrying its byte in order.

Source files
------------

// File: rtl/uart_rx_packer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_packer
//  Description : Pops bytes from a UART RX FIFO and packs BYTES consecutive
//                bytes into one 8*BYTES-bit word, with selectable byte order.
//                Partial words are discarded on an inter-byte timeout or on
//                an explicit flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_packer #(
    parameter int BYTES          = 2,       // bytes per word, 1..8
    parameter bit MSB_FIRST      = 1'b1,    // 1: first byte lands in the top lane
    parameter int TIMEOUT_CYCLES = 100000   // 0 disables the inter-byte timeout
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               rx_empty,
    input  logic [7:0]         r_data,
    output logic               rd_uart,
    output logic               uart_en,
    output logic [8*BYTES-1:0] uart_data,
    output logic               timeout_err,
    output logic               busy
);

    localparam int               IDX_W  = $clog2(BYTES + 1);
    localparam int               WORD_W = 8 * BYTES;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(BYTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   slot;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               rd_q, rd_d;
    logic               en_q, en_d;
    logic               to_q, to_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic               expire;

    // A byte is taken only when the previous pop has already been issued,
    // which limits the rate to one byte every two cycles. Flush has priority.
    assign accept = !rx_empty && !rd_q && !flush;

    // Byte lane addressed by the current index under the chosen byte order.
    assign slot = MSB_FIRST ? (C_LAST - idx_q) : idx_q;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int               CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;

            // Expiry needs a full idle count in COLLECT; an accept or a flush
            // in the same cycle takes priority.
            assign expire = (state_q == ST_COLLECT) && !accept && !flush &&
                            (cnt_q == C_CNT_MAX);

            // Idle-cycle counter: restarts on every accept and outside COLLECT.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if ((state_q != ST_COLLECT) || accept || flush || expire) begin
                    cnt_q <= '0;
                end else if (cnt_q != C_CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    // Next-state, assembly and output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        data_d  = data_q;
        rd_d    = 1'b0;
        en_d    = 1'b0;
        to_d    = 1'b0;

        // Drop the incoming byte into its lane; the completed word below is
        // read from asm_d so the final byte is included in the same cycle.
        if (accept) begin
            for (int j = 0; j < BYTES; j++) begin
                if (slot == IDX_W'(j)) begin
                    asm_d[8*j +: 8] = r_data;
                end
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (accept) begin
            rd_d = 1'b1;
            if (idx_q == C_LAST) begin
                data_d  = asm_d;
                en_d    = 1'b1;
                idx_d   = '0;
                state_d = ST_IDLE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_COLLECT;
            end
        end else if ((state_q == ST_COLLECT) && expire) begin
            idx_d   = '0;
            state_d = ST_IDLE;
            to_d    = 1'b1;
        end

        busy_d = (idx_d != '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            en_q    <= en_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
        end
    end

    assign rd_uart     = rd_q;
    assign uart_en     = en_q;
    assign uart_data   = data_q;
    assign timeout_err = to_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_packer
//  Description : Four packer configurations fed from bench FIFO models, with
//                a word-level reference model, vector table and corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_packer;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  flush_v = '0;
    logic [3:0]  rx_empty_v;
    logic [7:0]  rdat [4];
    logic [3:0]  rd_v, en_v, to_v, busy_v;
    logic [15:0] d0;
    logic [31:0] d1;
    logic [23:0] d2;
    logic [7:0]  d3;

    logic [7:0]  mem [4][256];
    int          head [4];
    int          tail [4];

    logic [63:0] exp_w [4][64];
    int          exp_wr [4];
    int          exp_rd [4];
    logic [7:0]  part [4][8];
    int          pcnt [4];
    bit          to_ok [4];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int              k;
        int              n;
        logic [3:0][7:0] b;
        logic [63:0]     w;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        assign rx_empty_v[g] = (head[g] == tail[g]);
        assign rdat[g]       = mem[g][head[g] % 256];
    end

    uart_rx_packer #(.BYTES(2), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush_v[0]), .rx_empty(rx_empty_v[0]), .r_data(rdat[0]),
        .rd_uart(rd_v[0]), .uart_en(en_v[0]), .uart_data(d0), .timeout_err(to_v[0]), .busy(busy_v[0]));
    uart_rx_packer #(.BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush_v[1]), .rx_empty(rx_empty_v[1]), .r_data(rdat[1]),
        .rd_uart(rd_v[1]), .uart_en(en_v[1]), .uart_data(d1), .timeout_err(to_v[1]), .busy(busy_v[1]));
    uart_rx_packer #(.BYTES(3), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(0)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush_v[2]), .rx_empty(rx_empty_v[2]), .r_data(rdat[2]),
        .rd_uart(rd_v[2]), .uart_en(en_v[2]), .uart_data(d2), .timeout_err(to_v[2]), .busy(busy_v[2]));
    uart_rx_packer #(.BYTES(1), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(4)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush_v[3]), .rx_empty(rx_empty_v[3]), .r_data(rdat[3]),
        .rd_uart(rd_v[3]), .uart_en(en_v[3]), .uart_data(d3), .timeout_err(to_v[3]), .busy(busy_v[3]));

    function automatic logic [63:0] dat(input int k);
        case (k)
            0:       return {48'h0, d0};
            1:       return {32'h0, d1};
            2:       return {40'h0, d2};
            default: return {56'h0, d3};
        endcase
    endfunction

    function automatic int by(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit mf(input int k);
        return (k != 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Reference model: collect bytes, form a word arithmetically when full.
    task automatic model_add(input int k, input logic [7:0] b);
        logic [63:0] w;
        part[k][pcnt[k]] = b;
        pcnt[k]++;
        if (pcnt[k] == by(k)) begin
            w = '0;
            for (int i = 0; i < by(k); i++) begin
                if (mf(k)) w = (w << 8) | {56'h0, part[k][i]};
                else       w = w | ({56'h0, part[k][i]} << (8 * i));
            end
            exp_w[k][exp_wr[k] % 64] = w;
            exp_wr[k]++;
            pcnt[k] = 0;
        end
    endtask

    task automatic model_drop(input int k);
        pcnt[k] = 0;
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][tail[k] % 256] = b;
        tail[k]++;
        model_add(k, b);
    endtask

    task automatic wait_word(input int k, input logic [63:0] w, input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (en_v[k]) begin
                chk(name, dat(k), w);
                seen = 1'b1;
            end
        end
        if (!seen) fail(name, "no uart_en within 60 cycles");
    endtask

    task automatic pop_loop();
        forever begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rd_v[k]) head[k] <= head[k] + 1;
            end
        end
    endtask

    task automatic monitor();
        logic [63:0] last_w [4];
        bit          prev_rd [4];
        for (int k = 0; k < 4; k++) begin
            last_w[k]  = '0;
            prev_rd[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (rst) begin
                    last_w[k]  = '0;
                    prev_rd[k] = 1'b0;
                end else begin
                    if (rd_v[k]) chk("rd_not_back_to_back", 64'(prev_rd[k]), 64'h0);
                    prev_rd[k] = rd_v[k];
                    if (en_v[k]) begin
                        chk("en_with_rd", 64'(rd_v[k]), 64'h1);
                        if (exp_rd[k] < exp_wr[k]) begin
                            chk("model_word", dat(k), exp_w[k][exp_rd[k] % 64]);
                            last_w[k] = exp_w[k][exp_rd[k] % 64];
                            exp_rd[k]++;
                        end else begin
                            fail("model_word", "uart_en with no word expected");
                        end
                    end else begin
                        chk("data_hold", dat(k), last_w[k]);
                    end
                    if (!to_ok[k]) chk("no_timeout_err", 64'(to_v[k]), 64'h0);
                end
            end
        end
    endtask

    initial begin
        int          n_rd, n_en, n_to, first_rd, en_c, to_c;
        logic [63:0] got;

        tbl[0] = '{0, 2, 32'h0000_3412, 64'h1234};
        tbl[1] = '{1, 4, 32'h0180_FF00, 64'h0180_FF00};
        tbl[2] = '{2, 3, 32'h0001_ADDE, 64'hDE_AD01};
        tbl[3] = '{3, 1, 32'h0000_005A, 64'h5A};
        tbl[4] = '{0, 2, 32'h0000_00FF, 64'hFF00};
        tbl[5] = '{2, 3, 32'h0030_2010, 64'h10_2030};
        tbl[6] = '{1, 4, 32'hD4C3_B2A1, 64'hD4C3_B2A1};

        fork
            monitor();
            pop_loop();
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_rd_uart", 64'(rd_v[k]), 64'h0);
            chk("rst_uart_en", 64'(en_v[k]), 64'h0);
            chk("rst_timeout_err", 64'(to_v[k]), 64'h0);
            chk("rst_busy", 64'(busy_v[k]), 64'h0);
            chk("rst_uart_data", dat(k), 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < tbl[i].n; j++) push(tbl[i].k, tbl[i].b[j]);
            wait_word(tbl[i].k, tbl[i].w, "table_word");
            @(negedge clk);
        end

        // 2-byte MSB-first: exactly two pops, one uart_en, value held
        push(0, 8'hA5);
        push(0, 8'h3C);
        n_rd = 0; n_en = 0; got = '0;
        repeat (12) begin
            @(negedge clk);
            if (rd_v[0]) n_rd++;
            if (en_v[0]) begin n_en++; got = dat(0); end
        end
        chk("t1_rd_pulses", 64'(n_rd), 64'd2);
        chk("t1_en_pulses", 64'(n_en), 64'd1);
        chk("t1_word", got, 64'hA53C);
        chk("t1_hold", dat(0), 64'hA53C);

        // 4-byte LSB-first back to back: latency 2*BYTES-1
        push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'h44);
        first_rd = -1; en_c = -1; got = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_v[1] && first_rd < 0) first_rd = c;
            if (en_v[1]) begin en_c = c; got = dat(1); end
        end
        chk("t2_word", got, 64'h4433_2211);
        chk("t2_latency", 64'(en_c - first_rd), 64'd6);

        // Timeout on a starved partial word
        to_ok[0] = 1'b1;
        push(0, 8'h55);
        model_drop(0);
        first_rd = -1; to_c = -1; n_to = 0; n_en = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_v[0] && first_rd < 0) begin
                first_rd = c;
                chk("t3_busy_while_partial", 64'(busy_v[0]), 64'h1);
            end
            if (to_v[0]) begin
                n_to++;
                to_c = c;
                chk("t3_busy_at_err", 64'(busy_v[0]), 64'h0);
            end
            if (en_v[0]) n_en++;
        end
        chk("t3_err_pulses", 64'(n_to), 64'd1);
        chk("t3_err_delay", 64'(to_c - first_rd), 64'd16);
        chk("t3_no_uart_en", 64'(n_en), 64'd0);
        chk("t3_busy_after", 64'(busy_v[0]), 64'h0);
        to_ok[0] = 1'b0;
        push(0, 8'hDE);
        push(0, 8'hAD);
        wait_word(0, 64'hDEAD, "t3_word_after_timeout");
        @(negedge clk);

        // Flush with a byte waiting in the FIFO
        push(2, 8'hAA);
        push(2, 8'hBB);
        repeat (5) @(negedge clk);
        chk("t4_busy_before_flush", 64'(busy_v[2]), 64'h1);
        flush_v[2] = 1'b1;
        model_drop(2);
        push(2, 8'h01);
        repeat (3) begin
            @(negedge clk);
            chk("t4_no_pop_in_flush", 64'(rd_v[2]), 64'h0);
        end
        chk("t4_busy_after_flush", 64'(busy_v[2]), 64'h0);
        chk("t4_byte_kept", 64'(rx_empty_v[2]), 64'h0);
        flush_v[2] = 1'b0;
        push(2, 8'h02);
        push(2, 8'h03);
        wait_word(2, 64'h01_0203, "t4_word_after_flush");
        @(negedge clk);

        // Reset in the middle of a word
        push(0, 8'h77);
        repeat (2) @(negedge clk);
        chk("t5_busy_before_rst", 64'(busy_v[0]), 64'h1);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) model_drop(k);
        @(negedge clk);
        chk("t5_rst_rd_uart", 64'(rd_v[0]), 64'h0);
        chk("t5_rst_uart_en", 64'(en_v[0]), 64'h0);
        chk("t5_rst_timeout_err", 64'(to_v[0]), 64'h0);
        chk("t5_rst_busy", 64'(busy_v[0]), 64'h0);
        chk("t5_rst_uart_data", dat(0), 64'h0);
        rst = 1'b0;
        push(0, 8'hBE);
        push(0, 8'hEF);
        wait_word(0, 64'hBEEF, "t5_word_after_rst");
        @(negedge clk);

        // BYTES=1 stream
        for (int i = 0; i < 16; i++) push(3, 8'(i));
        n_en = 0;
        repeat (40) begin
            @(negedge clk);
            if (en_v[3]) n_en++;
        end
        chk("t6_en_pulses", 64'(n_en), 64'd16);

        // Randomised words with random gaps on every configuration
        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < by(k); j++) begin
                    push(k, 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        end
        repeat (80) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rand_all_words_seen", 64'(exp_rd[k]), 64'(exp_wr[k]));
            chk("rand_fifo_drained", 64'(head[k]), 64'(tail[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
